// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the iterative divider.
interface div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve directly from IDLE to DONE.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic            is_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            done_q;

  logic            op_signed;
  logic            op_rem;
  logic            sgn1;
  logic            sgn2;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] result_next;

  always_comb begin
    op_signed = ~bus.funct3[0];
    op_rem    = bus.funct3[1];
    sgn1      = op_signed & bus.rs1[XLEN-1];
    sgn2      = op_signed & bus.rs2[XLEN-1];
    abs1      = sgn1 ? -bus.rs1 : bus.rs1;
    abs2      = sgn2 ? -bus.rs2 : bus.rs2;
    div_zero  = (bus.rs2 == '0);
    overflow  = op_signed && (bus.rs1 == MinInt) && (bus.rs2 == '1);
    if (div_zero) begin
      special_res = op_rem ? bus.rs1 : '1;
    end else begin
      special_res = op_rem ? '0 : MinInt;
    end

    // Partial remainder needs one extra bit: the shifted value may reach 2*divisor-1.
    rem_shift   = {rem_q, dvd_q[XLEN-1]};
    rem_ge      = (rem_shift >= {1'b0, dvs_q});
    rem_next    = rem_ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];
    // Quotient bits fill the dividend register as its top bits are consumed.
    quo_next    = {dvd_q[XLEN-2:0], rem_ge};
    if (is_rem_q) begin
      result_next = neg_rem_q ? -rem_next : rem_next;
    end else begin
      result_next = neg_quo_q ? -quo_next : quo_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && bus.funct3[2] && !bus.flush) begin
            is_rem_q  <= op_rem;
            neg_quo_q <= sgn1 ^ sgn2;
            neg_rem_q <= sgn1;
            dvd_q     <= abs1;
            dvs_q     <= abs2;
            rem_q     <= '0;
            count_q   <= '0;
            if (div_zero || overflow) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q  <= StCalc;
            end
          end
        end
        StCalc: begin
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            rem_q   <= rem_next;
            dvd_q   <= quo_next;
            count_q <= count_q + CntW'(1);
            if (count_q == CntW'(XLEN - 1)) begin
              result_q <= result_next;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, corner sequences, randomized ops vs model.
module tb_div_unit;
  localparam int unsigned XLEN = 32;
  localparam logic [2:0] OpDiv  = 3'b100;
  localparam logic [2:0] OpDivu = 3'b101;
  localparam logic [2:0] OpRem  = 3'b110;
  localparam logic [2:0] OpRemu = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  div_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Counts negedges from the current cycle until done; 60 means it never came.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (lat < 60 && !bus.done) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(f3, a, b);
    wait_done(1, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, bus.result, exp);
    chk({name, " busy at done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({name, " done one cycle"}, 32'(bus.done), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int          lat;
    int          seen;
    logic [31:0] prev;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;

    vecs.push_back('{OpDivu, 32'd100, 32'd7, 32'd14, 33});
    vecs.push_back('{OpRemu, 32'd100, 32'd7, 32'd2, 33});
    vecs.push_back('{OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
    vecs.push_back('{OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{OpRemu, 32'd5, 32'd0, 32'd5, 1});
    vecs.push_back('{OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
    vecs.push_back('{OpDivu, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33});
    vecs.push_back('{OpRemu, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33});
    vecs.push_back('{OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});
    vecs.push_back('{OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});

    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.rs1    = '0;
    bus.rs2    = '0;
    bus.flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset result", bus.result, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Illegal funct3 in IDLE is ignored.
    issue(3'b000, 32'd9, 32'd3);
    chk("illegal busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (5) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("illegal no done", 32'(seen), 32'd0);

    // Flush mid-calculation: idle next cycle, no done, result untouched.
    run_op("pre-flush", OpDivu, 32'hAA, 32'd2, 32'h55, 33);
    prev = bus.result;
    issue(OpDivu, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (40) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("flush no done", 32'(seen), 32'd0);
    chk("flush result kept", bus.result, prev);
    run_op("post-flush", OpDivu, 32'd9, 32'd3, 32'd3, 33);

    // Flush and start together in IDLE: flush wins.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = OpDivu;
    bus.rs1    = 32'd100;
    bus.rs2    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush+start busy", 32'(bus.busy), 32'd0);

    // Start while busy is ignored; the original op completes unchanged.
    issue(OpDivu, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = OpRemu;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(6, lat);
    chk("busy-start latency", 32'(lat), 32'd33);
    chk("busy-start result", bus.result, 32'd14);

    // Start presented during DONE is not accepted.
    bus.start  = 1'b1;
    bus.funct3 = OpDivu;
    bus.rs1    = 32'd9;
    bus.rs2    = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done-start busy", 32'(bus.busy), 32'd0);
    chk("done-start result", bus.result, 32'd14);

    // Randomized operations against the model.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'(4 + $urandom_range(3));
      a  = $urandom;
      case ($urandom_range(9))
        0:       b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(15, 1));
        3:       b = $urandom >> $urandom_range(31);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d f3=%b a=%h b=%h", n, f3, a, b), f3, a, b, model(f3, a, b),
             model_lat(f3, a, b));
    end

    // Asynchronous reset mid-operation.
    issue(OpDivu, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(bus.busy), 32'd0);
    chk("async rst done", 32'(bus.done), 32'd0);
    chk("async rst result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("async rst no done", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
